// File: rtl/fetch_queue_if.sv
// Fetch queue bus bundle: program-memory req/ack port, branch redirect and
// the opcode valid/ready port toward decode.
interface fetch_queue_if #(
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 4
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic [15:0]       mem_rdata;
   logic              mem_ack;
   logic              br_taken;
   logic [ADDR_W-1:0] br_target;
   logic              op_ready;
   logic              op_valid;
   logic [15:0]       opCode;
   logic [ADDR_W-1:0] op_pc;
   logic [CNT_W-1:0]  count;

   modport master (
      output mem_req, mem_addr, op_valid, opCode, op_pc, count,
      input  mem_rdata, mem_ack, br_taken, br_target, op_ready
   );

   modport slave (
      input  mem_req, mem_addr, op_valid, opCode, op_pc, count,
      output mem_rdata, mem_ack, br_taken, br_target, op_ready
   );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch: owns the PC, fetches opcodes over req/ack into a small
// FIFO and presents them to decode; a taken branch flushes and redirects.
module fetch_queue #(
   parameter int              ADDR_W   = 8,
   parameter int              DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input logic           clk,
   input logic           rst,
   fetch_queue_if.master bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   typedef struct packed {
      logic [15:0]       op;
      logic [ADDR_W-1:0] pc;
   } entry_t;

   typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

   state_t              state, state_nx;
   logic [ADDR_W-1:0]   pc, pc_nx, addr_q, addr_nx, held_pc;
   entry_t [DEPTH-1:0]  fifo_mem;
   logic [PTR_W-1:0]    rd_ptr, wr_ptr;
   logic [CNT_W-1:0]    cnt, cnt_pop, cnt_push;
   logic                flush, push, pop, op_valid_w;
   logic [ADDR_W-1:0]   op_pc_w;

   // A branch flushes the queue and overrides any same-cycle push or pop.
   assign flush      = bus.br_taken;
   assign op_valid_w = (cnt != '0);
   assign pop        = op_valid_w && bus.op_ready && !flush;
   assign push       = (state == REQ) && bus.mem_ack && !flush;
   assign cnt_pop    = cnt - CNT_W'(pop);
   assign cnt_push   = cnt_pop + CNT_W'(push);

   always_comb begin
      state_nx = state;
      pc_nx    = pc;
      case (state)
         IDLE: begin
            if (flush) begin
               pc_nx    = bus.br_target;
               state_nx = REQ;
            end else if (cnt_pop < DEPTH_C) begin
               state_nx = REQ;
            end
         end
         REQ: begin
            if (flush) begin
               pc_nx    = bus.br_target;
               state_nx = bus.mem_ack ? REQ : DRAIN;
            end else if (bus.mem_ack) begin
               pc_nx    = pc + ADDR_W'(1);
               state_nx = (cnt_push < DEPTH_C) ? REQ : IDLE;
            end
         end
         DRAIN: begin
            if (flush)       pc_nx    = bus.br_target;
            if (bus.mem_ack) state_nx = REQ;
         end
         default: state_nx = IDLE;
      endcase
      // The abandoned request keeps its address on the bus until it is acked.
      addr_nx = (state_nx == DRAIN) ? addr_q : pc_nx;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         pc       <= RESET_PC;
         addr_q   <= RESET_PC;
         held_pc  <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         cnt      <= '0;
         fifo_mem <= '0;
      end else begin
         state   <= state_nx;
         pc      <= pc_nx;
         addr_q  <= addr_nx;
         held_pc <= op_pc_w;
         if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
         end else begin
            if (push) begin
               fifo_mem[wr_ptr] <= {bus.mem_rdata, addr_q};
               wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt_push;
         end
      end
   end

   assign op_pc_w      = op_valid_w ? fifo_mem[rd_ptr].pc : held_pc;
   assign bus.mem_req  = (state != IDLE);
   assign bus.mem_addr = addr_q;
   assign bus.op_valid = op_valid_w;
   assign bus.opCode   = op_valid_w ? fifo_mem[rd_ptr].op : 16'h0000;
   assign bus.op_pc    = op_pc_w;
   assign bus.count    = cnt;
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector table, hand-written reset/wrap
// sequences, and randomized traffic against a queue-based reference model.
module tb_fetch_queue;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   fetch_queue_if #(.ADDR_W(8), .DEPTH(DEPTH)) bus ();
   fetch_queue_if #(.ADDR_W(8), .DEPTH(DEPTH)) wbus ();

   fetch_queue #(.ADDR_W(8), .DEPTH(DEPTH), .RESET_PC(8'h00)) u_dut (
      .clk(clk), .rst(rst), .bus(bus)
   );
   fetch_queue #(.ADDR_W(8), .DEPTH(DEPTH), .RESET_PC(8'hFE)) u_wrap (
      .clk(clk), .rst(rst), .bus(wbus)
   );

   typedef struct {
      string       nm;
      logic        r;
      logic        ack;
      logic [15:0] rd;
      logic        br;
      logic [7:0]  tgt;
      logic        rdy;
      logic        req;
      logic [7:0]  addr;
      logic        vld;
      logic [15:0] op;
      logic [7:0]  opc;
      logic [2:0]  cnt;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t mk(string nm, logic r, logic ack, logic [15:0] rd, logic br,
                               logic [7:0] tgt, logic rdy, logic req, logic [7:0] addr,
                               logic vld, logic [15:0] op, logic [7:0] opc, logic [2:0] cnt);
      vec_t v;
      v.nm = nm; v.r = r; v.ack = ack; v.rd = rd; v.br = br; v.tgt = tgt; v.rdy = rdy;
      v.req = req; v.addr = addr; v.vld = vld; v.op = op; v.opc = opc; v.cnt = cnt;
      return v;
   endfunction

   task automatic chk(string nm, logic req, logic [7:0] addr, logic vld,
                      logic [15:0] op, logic [7:0] opc, logic [2:0] cnt);
      checks++;
      if (bus.mem_req !== req || bus.mem_addr !== addr || bus.op_valid !== vld ||
          bus.opCode !== op || bus.op_pc !== opc || bus.count !== cnt) begin
         failures++;
         $display("FAIL %s: got req=%b addr=%h vld=%b op=%h pc=%h cnt=%0d, want req=%b addr=%h vld=%b op=%h pc=%h cnt=%0d",
                  nm, bus.mem_req, bus.mem_addr, bus.op_valid, bus.opCode, bus.op_pc, bus.count,
                  req, addr, vld, op, opc, cnt);
      end
   endtask

   // Reference model: an ordered list of buffered {opcode, pc} plus the
   // outstanding-request bookkeeping, updated once per clock edge.
   typedef struct {
      logic [15:0] op;
      logic [7:0]  pc;
   } ent_t;

   ent_t       mq[$];
   bit         m_pend, m_drop;
   logic [7:0] m_pc, m_addr, m_last;

   task automatic model_reset();
      mq.delete();
      m_pend = 0; m_drop = 0; m_pc = 8'h00; m_addr = 8'h00; m_last = 8'h00;
   endtask

   task automatic model_step(logic ack, logic [15:0] rd, logic br, logic [7:0] tgt, logic rdy);
      if (mq.size() != 0) m_last = mq[0].pc;
      if (br) begin
         mq.delete();
         m_pc = tgt;
         if (m_pend && !ack) m_drop = 1;
         else begin
            m_pend = 1; m_drop = 0; m_addr = m_pc;
         end
      end else begin
         if (rdy && mq.size() != 0) void'(mq.pop_front());
         if (m_pend && ack) begin
            if (!m_drop) begin
               mq.push_back('{op: rd, pc: m_addr});
               m_pc = m_pc + 8'd1;
            end
            m_drop = 0;
            m_pend = (mq.size() < DEPTH);
            m_addr = m_pc;
         end else if (!m_pend) begin
            m_pend = (mq.size() < DEPTH);
            m_addr = m_pc;
         end
      end
   endtask

   task automatic set_in(logic ack, logic [15:0] rd, logic br, logic [7:0] tgt, logic rdy);
      bus.mem_ack = ack; bus.mem_rdata = rd; bus.br_taken = br;
      bus.br_target = tgt; bus.op_ready = rdy;
   endtask

   initial begin
      logic [7:0] ea;
      int lat;
      logic ack, br, rdy;
      logic [15:0] rd;
      logic [7:0] tgt;

      set_in(0, 16'h0, 0, 8'h0, 0);
      wbus.mem_ack = 0; wbus.mem_rdata = 16'h0; wbus.br_taken = 0;
      wbus.br_target = 8'h0; wbus.op_ready = 0;

      //            name      rst ack rdata     br tgt    rdy  req addr  vld op        pc     cnt
      // back-to-back fetch with decoder always ready
      vt.push_back(mk("t1_rst", 1, 0, 16'h0000, 0, 8'h00, 1,  0, 8'h00, 0, 16'h0000, 8'h00, 0));
      vt.push_back(mk("t1_a",   0, 0, 16'h0000, 0, 8'h00, 1,  1, 8'h00, 0, 16'h0000, 8'h00, 0));
      vt.push_back(mk("t1_b",   0, 1, 16'hA000, 0, 8'h00, 1,  1, 8'h01, 1, 16'hA000, 8'h00, 1));
      vt.push_back(mk("t1_c",   0, 1, 16'hA001, 0, 8'h00, 1,  1, 8'h02, 1, 16'hA001, 8'h01, 1));
      vt.push_back(mk("t1_d",   0, 1, 16'hA002, 0, 8'h00, 1,  1, 8'h03, 1, 16'hA002, 8'h02, 1));
      // fill to full, stale ack while idle, one pop resumes fetching
      vt.push_back(mk("t2_rst", 1, 0, 16'h0000, 0, 8'h00, 0,  0, 8'h00, 0, 16'h0000, 8'h00, 0));
      vt.push_back(mk("t2_a",   0, 0, 16'h0000, 0, 8'h00, 0,  1, 8'h00, 0, 16'h0000, 8'h00, 0));
      vt.push_back(mk("t2_b",   0, 1, 16'hA000, 0, 8'h00, 0,  1, 8'h01, 1, 16'hA000, 8'h00, 1));
      vt.push_back(mk("t2_c",   0, 1, 16'hA001, 0, 8'h00, 0,  1, 8'h02, 1, 16'hA000, 8'h00, 2));
      vt.push_back(mk("t2_d",   0, 1, 16'hA002, 0, 8'h00, 0,  1, 8'h03, 1, 16'hA000, 8'h00, 3));
      vt.push_back(mk("t2_full",0, 1, 16'hA003, 0, 8'h00, 0,  0, 8'h04, 1, 16'hA000, 8'h00, 4));
      vt.push_back(mk("t2_hold",0, 0, 16'h0000, 0, 8'h00, 0,  0, 8'h04, 1, 16'hA000, 8'h00, 4));
      vt.push_back(mk("t2_stale",0,1, 16'hDEAD, 0, 8'h00, 0,  0, 8'h04, 1, 16'hA000, 8'h00, 4));
      vt.push_back(mk("t2_pop", 0, 0, 16'h0000, 0, 8'h00, 1,  1, 8'h04, 1, 16'hA001, 8'h01, 3));
      vt.push_back(mk("t2_wait",0, 0, 16'h0000, 0, 8'h00, 0,  1, 8'h04, 1, 16'hA001, 8'h01, 3));
      // branch while request to 5 is pending, late ack discarded
      vt.push_back(mk("t3_pp",  0, 1, 16'hA004, 0, 8'h00, 1,  1, 8'h05, 1, 16'hA002, 8'h02, 3));
      vt.push_back(mk("t3_br",  0, 0, 16'h0000, 1, 8'h40, 1,  1, 8'h05, 0, 16'h0000, 8'h02, 0));
      vt.push_back(mk("t3_dr1", 0, 0, 16'h0000, 0, 8'h00, 1,  1, 8'h05, 0, 16'h0000, 8'h02, 0));
      vt.push_back(mk("t3_dr2", 0, 0, 16'h0000, 0, 8'h00, 1,  1, 8'h05, 0, 16'h0000, 8'h02, 0));
      vt.push_back(mk("t3_drk", 0, 1, 16'hA005, 0, 8'h00, 1,  1, 8'h40, 0, 16'h0000, 8'h02, 0));
      vt.push_back(mk("t3_tgt", 0, 1, 16'hB040, 0, 8'h00, 0,  1, 8'h41, 1, 16'hB040, 8'h40, 1));
      // branch coincident with ack: no drain
      vt.push_back(mk("t4_rst", 1, 0, 16'h0000, 0, 8'h00, 1,  0, 8'h00, 0, 16'h0000, 8'h00, 0));
      vt.push_back(mk("t4_a",   0, 0, 16'h0000, 0, 8'h00, 1,  1, 8'h00, 0, 16'h0000, 8'h00, 0));
      vt.push_back(mk("t4_b",   0, 1, 16'hA000, 0, 8'h00, 1,  1, 8'h01, 1, 16'hA000, 8'h00, 1));
      vt.push_back(mk("t4_c",   0, 1, 16'hA001, 0, 8'h00, 1,  1, 8'h02, 1, 16'hA001, 8'h01, 1));
      vt.push_back(mk("t4_brak",0, 1, 16'hA002, 1, 8'h10, 1,  1, 8'h10, 0, 16'h0000, 8'h01, 0));
      vt.push_back(mk("t4_w",   0, 0, 16'h0000, 0, 8'h00, 1,  1, 8'h10, 0, 16'h0000, 8'h01, 0));
      vt.push_back(mk("t4_keep",0, 1, 16'hC010, 0, 8'h00, 1,  1, 8'h11, 1, 16'hC010, 8'h10, 1));
      // branch taken while idle
      vt.push_back(mk("t7_rst", 1, 0, 16'h0000, 0, 8'h00, 0,  0, 8'h00, 0, 16'h0000, 8'h00, 0));
      vt.push_back(mk("t7_ibr", 0, 0, 16'h0000, 1, 8'h80, 0,  1, 8'h80, 0, 16'h0000, 8'h00, 0));
      vt.push_back(mk("t7_ack", 0, 1, 16'hD080, 0, 8'h00, 0,  1, 8'h81, 1, 16'hD080, 8'h80, 1));

      foreach (vt[i]) begin
         @(negedge clk);
         rst = vt[i].r;
         set_in(vt[i].ack, vt[i].rd, vt[i].br, vt[i].tgt, vt[i].rdy);
         @(posedge clk);
         #1;
         chk(vt[i].nm, vt[i].req, vt[i].addr, vt[i].vld, vt[i].op, vt[i].opc, vt[i].cnt);
      end

      // async reset mid-REQ with three entries buffered
      @(negedge clk); rst = 1; set_in(0, 16'h0, 0, 8'h0, 0);
      @(negedge clk); rst = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); set_in(1, 16'hA000 + 16'(k), 0, 8'h0, 0);
      end
      @(negedge clk); set_in(0, 16'h0, 0, 8'h0, 0);
      #1 chk("t6_pre", 1, 8'h03, 1, 16'hA000, 8'h00, 3);
      #2 rst = 1;
      #1 chk("t6_async", 0, 8'h00, 0, 16'h0000, 8'h00, 0);
      checks++;
      if (wbus.mem_req !== 1'b0 || wbus.mem_addr !== 8'hFE) begin
         failures++;
         $display("FAIL t6_wrap_rst: got req=%b addr=%h, want req=0 addr=fe", wbus.mem_req, wbus.mem_addr);
      end
      @(negedge clk); rst = 0; set_in(1, 16'hDEAD, 0, 8'h0, 0);
      @(posedge clk); #1 chk("t6_restart", 1, 8'h00, 0, 16'h0000, 8'h00, 0);
      @(negedge clk); set_in(0, 16'h0, 0, 8'h0, 0);
      @(posedge clk); #1 chk("t6_noack", 1, 8'h00, 0, 16'h0000, 8'h00, 0);

      // RESET_PC=FE instance: address and op_pc wrap through 0
      wbus.op_ready = 1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         ea = 8'hFE + 8'(k);
         checks++;
         if (wbus.mem_req !== 1'b1 || wbus.mem_addr !== ea ||
             (k == 0 && wbus.op_valid !== 1'b0) ||
             (k > 0 && (wbus.op_valid !== 1'b1 || wbus.op_pc !== ea - 8'd1 ||
                        wbus.opCode !== {8'hA0, ea - 8'd1}))) begin
            failures++;
            $display("FAIL t5_wrap[%0d]: got req=%b addr=%h vld=%b pc=%h op=%h, want addr=%h pc=%h",
                     k, wbus.mem_req, wbus.mem_addr, wbus.op_valid, wbus.op_pc, wbus.opCode,
                     ea, ea - 8'd1);
         end
         wbus.mem_ack = 1;
         wbus.mem_rdata = {8'hA0, wbus.mem_addr};
      end
      @(negedge clk); wbus.mem_ack = 0; wbus.op_ready = 0;

      // randomized traffic against the reference model
      @(negedge clk); rst = 1; set_in(0, 16'h0, 0, 8'h0, 0);
      @(negedge clk); rst = 0;
      model_reset();
      lat = $urandom_range(0, 3);
      for (int n = 0; n < 2500; n++) begin
         br  = ($urandom_range(0, 11) == 0);
         tgt = 8'($urandom);
         rd  = 16'($urandom);
         rdy = ($urandom_range(0, 3) < (((n / 400) % 2 == 1) ? 3 : 1));
         if (bus.mem_req) begin
            if (lat == 0) begin ack = 1; lat = $urandom_range(0, 3); end
            else begin ack = 0; lat--; end
         end else begin
            ack = ($urandom_range(0, 7) == 0);
         end
         set_in(ack, rd, br, tgt, rdy);
         @(posedge clk);
         model_step(ack, rd, br, tgt, rdy);
         @(negedge clk);
         chk("rand", m_pend, m_addr, mq.size() != 0,
             (mq.size() != 0) ? mq[0].op : 16'h0000,
             (mq.size() != 0) ? mq[0].pc : m_last, 3'(mq.size()));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
